// File: rtl/dac_tx_pkg.sv
// Shared types and constants for the DAC transmit path.
package dac_tx_pkg;

    localparam int unsigned DAC_BITS     = 12;
    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned PAD_BITS     = 4;
    localparam int unsigned MIDSCALE     = 2048;
    // SCLK half-periods spent in SHIFT: 16 falls, 15 rises, then a closing low half
    localparam int unsigned HALF_PERIODS = 2 * FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        STOP
    } tx_state_t;

    // Serial frame: four zero pad bits followed by the DAC code, MSB first
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DAC_BITS-1:0] code);
        return {PAD_BITS'(0), code};
    endfunction

endpackage

// File: rtl/sample_to_dac_code.sv
// Signed fixed-point sample to 12-bit offset-binary DAC code with saturation.
module sample_to_dac_code
    import dac_tx_pkg::*;
#(
    parameter int unsigned W    = 25,
    parameter int unsigned FRAC = 14
) (
    input  logic signed [W-1:0]  sample,
    output logic [DAC_BITS-1:0]  code_c
);

    // Keep DAC_BITS-1 fractional bits so +/-1.0 lands on the code range edges
    localparam int unsigned SHAMT = FRAC - (DAC_BITS - 1);
    localparam logic signed [W-1:0] CODE_MAX = W'(MIDSCALE - 1);
    localparam logic signed [W-1:0] CODE_MIN = ~CODE_MAX;

    logic signed [W-1:0] scaled;

    // Scale, clamp to the signed 12-bit range, then offset by midscale (MSB flip)
    always_comb begin
        scaled = sample >>> SHAMT;
        if (scaled > CODE_MAX) begin
            code_c = '1;
        end else if (scaled < CODE_MIN) begin
            code_c = '0;
        end else begin
            code_c = {~scaled[DAC_BITS-1], scaled[DAC_BITS-2:0]};
        end
    end

endmodule

// File: rtl/dac_tx_serializer.sv
// Sample strobe generator, capture buffer and 16-bit serial DAC transmitter.
module dac_tx_serializer
    import dac_tx_pkg::*;
#(
    parameter int unsigned W          = 25,
    parameter int unsigned FRAC       = 14,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_DIV = 2268
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic signed [W-1:0] Sample,
    output logic                Sample_En,
    output logic                SYNC,
    output logic                SCLK,
    output logic                DIN,
    output logic                Busy,
    output logic                Overrun
);

    localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV);
    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned EDGE_W = $clog2(HALF_PERIODS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(HALF_PERIODS - 1);

    logic [CNT_W-1:0]      smp_cnt;
    logic                  capture;
    logic [DAC_BITS-1:0]   conv_code_c;
    logic [DAC_BITS-1:0]   pend_code;
    logic                  pend_valid;
    tx_state_t             state;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  div_done_c;
    logic                  take_pend_c;
    logic                  bypass_c;
    logic [FRAME_BITS-1:0] load_frame_c;

    sample_to_dac_code #(
        .W    (W),
        .FRAC (FRAC)
    ) u_conv (
        .sample (Sample),
        .code_c (conv_code_c)
    );

    // Sample period counter; capture trails the strobe by one cycle so the filter output has settled
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            smp_cnt   <= '0;
            Sample_En <= 1'b0;
            capture   <= 1'b0;
        end else begin
            smp_cnt   <= (smp_cnt == CNT_LAST) ? '0 : smp_cnt + CNT_W'(1);
            Sample_En <= (smp_cnt == CNT_LAST);
            capture   <= Sample_En;
        end
    end

    // Frame start decisions; an idle transmitter takes a fresh capture directly to save a cycle
    always_comb begin
        div_done_c   = (div_cnt == DIV_LAST);
        take_pend_c  = (state == IDLE) && pend_valid;
        bypass_c     = (state == IDLE) && !pend_valid && capture;
        load_frame_c = make_frame(pend_valid ? pend_code : conv_code_c);
    end

    // Pending code slot and sticky overrun flag
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pend_code  <= '0;
            pend_valid <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            if (capture) begin
                pend_code <= conv_code_c;
            end
            if (capture && !bypass_c) begin
                pend_valid <= 1'b1;
            end else if (take_pend_c) begin
                pend_valid <= 1'b0;
            end
            if (capture && pend_valid && !take_pend_c) begin
                Overrun <= 1'b1;
            end
        end
    end

    // Frame FSM with SCLK divider and shift register
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            SYNC     <= 1'b1;
            SCLK     <= 1'b1;
            DIN      <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_pend_c || bypass_c) begin
                        state   <= LOAD;
                        div_cnt <= '0;
                        shreg   <= load_frame_c;
                        DIN     <= load_frame_c[FRAME_BITS-1];
                        SYNC    <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (div_done_c) begin
                        state    <= SHIFT;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_done_c) begin
                        div_cnt  <= '0;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (edge_cnt == EDGE_LAST) begin
                            state <= STOP;
                        end else if (!edge_cnt[0]) begin
                            SCLK <= 1'b0;
                        end else begin
                            SCLK  <= 1'b1;
                            shreg <= shreg << 1;
                            DIN   <= shreg[FRAME_BITS-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (div_done_c) begin
                        state <= IDLE;
                        SCLK  <= 1'b1;
                        SYNC  <= 1'b1;
                        Busy  <= 1'b0;
                        DIN   <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_tx_serializer.sv
// Randomized bench for dac_tx_serializer: a relaxed-rate instance and an overrunning instance.
module tb_dac_tx_serializer;

    localparam int unsigned W          = 25;
    localparam int unsigned FRAC       = 14;
    localparam int unsigned CD         = 2;
    localparam int          F          = 34 * CD;
    localparam int          RUN_CYCLES = 3000;

    logic                clk;
    logic [1:0]          rst_n;
    logic signed [W-1:0] smp [2];
    logic [1:0]          sen, sync, sclk, din, busy, ovr;

    dac_tx_serializer #(.W(W), .FRAC(FRAC), .CLK_DIV(CD), .SAMPLE_DIV(100)) u_dut_a (
        .CLK(clk), .Reset(rst_n[0]), .Sample(smp[0]), .Sample_En(sen[0]),
        .SYNC(sync[0]), .SCLK(sclk[0]), .DIN(din[0]), .Busy(busy[0]), .Overrun(ovr[0])
    );

    dac_tx_serializer #(.W(W), .FRAC(FRAC), .CLK_DIV(CD), .SAMPLE_DIV(40)) u_dut_b (
        .CLK(clk), .Reset(rst_n[1]), .Sample(smp[1]), .Sample_En(sen[1]),
        .SYNC(sync[1]), .SCLK(sclk[1]), .DIN(din[1]), .Busy(busy[1]), .Overrun(ovr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int sdiv [2]     = '{100, 40};
    int dir_val [7]  = '{0, 8192, 16384, 16777215, -16384, -8192, -16777216};
    int dir_code [7] = '{'h800, 'hC00, 'hFFF, 'hFFF, 'h000, 'h400, 'h000};
    int dir_idx      = 0;

    // Reference model state, one slot per instance
    int rel [2], free [2], pcode [2], cur_start [2], cur_code [2], capc [2];
    int exp_ovr [2], pv [2], act [2], run [2], upd [2], capf [2];
    int rx [2], nfall [2], prev_sclk [2], prev_sync [2], frames_done [2], frames_rx [2];
    int t, n, v, cc, rst_hold, rst_done;
    logic esen, esclk, fell;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic string tg(input string s, input int i);
        return $sformatf("%s_%s", s, (i == 0) ? "a" : "b");
    endfunction

    // Floor-divide by 2^(FRAC-11), clamp to signed 12-bit, shift to offset binary
    function automatic int dac_code(input int x);
        int q;
        int d;
        d = 1 << (FRAC - 11);
        if (x >= 0) q = x / d;
        else        q = -((-x + d - 1) / d);
        if (q > 2047)  q = 2047;
        if (q < -2048) q = -2048;
        return q + 2048;
    endfunction

    // SCLK level d cycles into a frame: high for LOAD and the first SHIFT half,
    // then low on even half-periods, with the final two half-periods low
    function automatic logic exp_sclk(input int d);
        int h;
        h = d / CD;
        return !(h >= 2 && (h % 2 == 0 || h == 33));
    endfunction

    task automatic next_sample(input int i, output int val, output int code);
        if (i == 0 && dir_idx < 7) begin
            val  = dir_val[dir_idx];
            code = dir_code[dir_idx];
            dir_idx++;
        end else begin
            case ($urandom_range(0, 3))
                0:       val = int'($urandom_range(0, 33554431)) - 16777216;
                1:       val = int'($urandom_range(0, 32767)) - 16384;
                2:       val = 16376 + int'($urandom_range(0, 15));
                default: val = -16392 + int'($urandom_range(0, 15));
            endcase
            code = dac_code(val);
        end
    endtask

    task automatic start_frame(input int i, input int ts, input int code);
        act[i]       = 1;
        cur_start[i] = ts;
        cur_code[i]  = code;
        free[i]      = ts + F + 1;
    endtask

    initial begin
        rst_n    = 2'b00;
        smp[0]   = '0;
        smp[1]   = '0;
        rst_hold = 0;
        rst_done = 0;
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; pv[i] = 0; act[i] = 0; exp_ovr[i] = 0; free[i] = 0;
            upd[i] = 0; capf[i] = 0; rx[i] = 0; nfall[i] = 0;
            prev_sclk[i] = 1; prev_sync[i] = 1; frames_done[i] = 0; frames_rx[i] = 0;
        end

        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(posedge clk);
            cyc++;
            #1;
            t = cyc;
            for (int i = 0; i < 2; i++) begin
                fell = 1'b0;
                if (!rst_n[i]) begin
                    run[i] = 0; pv[i] = 0; act[i] = 0; exp_ovr[i] = 0; free[i] = 0;
                    upd[i] = 0; capf[i] = 0; rx[i] = 0; nfall[i] = 0;
                    check_eq(tg("rst_sen", i),  sen[i],  0);
                    check_eq(tg("rst_sync", i), sync[i], 1);
                    check_eq(tg("rst_sclk", i), sclk[i], 1);
                    check_eq(tg("rst_din", i),  din[i],  0);
                    check_eq(tg("rst_busy", i), busy[i], 0);
                    check_eq(tg("rst_ovr", i),  ovr[i],  0);
                end else begin
                    if (!run[i]) begin
                        run[i] = 1;
                        rel[i] = t;
                    end
                    n = t - rel[i] + 1;
                    if (act[i] != 0 && t == cur_start[i] + F) begin
                        act[i] = 0;
                        frames_done[i]++;
                    end
                    if (pv[i] != 0 && free[i] <= t) begin
                        start_frame(i, t, pcode[i]);
                        pv[i] = 0;
                    end
                    if (capf[i] != 0) begin
                        capf[i] = 0;
                        if (pv[i] == 0 && free[i] <= t) begin
                            start_frame(i, t, capc[i]);
                        end else begin
                            if (pv[i] != 0) exp_ovr[i] = 1;
                            pv[i]    = 1;
                            pcode[i] = capc[i];
                        end
                    end
                    // Emulated filter: output register updates on the edge after the strobe
                    if (upd[i] != 0) begin
                        upd[i] = 0;
                        next_sample(i, v, cc);
                        smp[i]  = W'(v);
                        capc[i] = cc;
                        capf[i] = 1;
                    end
                    esen = (n % sdiv[i] == 0);
                    if (esen) upd[i] = 1;
                    esclk = (act[i] != 0) ? exp_sclk(t - cur_start[i]) : 1'b1;

                    check_eq(tg("sample_en", i), sen[i],  esen);
                    check_eq(tg("sync", i),      sync[i], (act[i] == 0) ? 1 : 0);
                    check_eq(tg("busy", i),      busy[i], (act[i] != 0) ? 1 : 0);
                    check_eq(tg("sclk", i),      sclk[i], esclk);
                    check_eq(tg("overrun", i),   ovr[i],  exp_ovr[i]);

                    if (!sync[i] && prev_sync[i] != 0) begin
                        rx[i]    = 0;
                        nfall[i] = 0;
                    end
                    if (!sync[i] && prev_sclk[i] != 0 && !sclk[i]) begin
                        rx[i] = ((rx[i] << 1) | int'(din[i])) & 'hFFFF;
                        nfall[i]++;
                        fell = 1'b1;
                    end
                    if (sync[i] && prev_sync[i] == 0) begin
                        check_eq(tg("frame", i), rx[i], cur_code[i]);
                        check_eq(tg("falls", i), nfall[i], 16);
                        frames_rx[i]++;
                    end
                end
                prev_sclk[i] = int'(sclk[i]);
                prev_sync[i] = int'(sync[i]);

                // Abort a frame on the overrunning instance at its 7th SCLK fall
                if (i == 1 && rst_done == 0 && exp_ovr[1] != 0 && nfall[1] == 7 && fell) begin
                    rst_n[1] = 1'b0;
                    rst_hold = 3;
                    rst_done = 1;
                end
            end

            if (c == 2) rst_n = 2'b11;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n[1] = 1'b1;
            end
        end

        check_eq("frames_a",     frames_rx[0], frames_done[0]);
        check_eq("frames_b",     frames_rx[1], frames_done[1]);
        check_eq("frames_a_min", (frames_rx[0] >= 20) ? 1 : 0, 1);
        check_eq("frames_b_min", (frames_rx[1] >= 20) ? 1 : 0, 1);
        check_eq("reset_hit",    rst_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_tx_serializer.md
# dac_tx_serializer

Output end of the audio path: periodically strobes the filter chain to advance one sample, captures the filtered signed fixed-point result, converts it to a 12-bit offset-binary DAC code with saturation, and shifts it out MSB-first as a 16-bit serial frame to an external DAC. It is the transmitter counterpart to the filter's sample interface: it generates the `Enable` the filter consumes and drains the `y` the filter produces.

## Interface
- `W`, 25: width of the signed sample input.
- `FRAC`, 14: fractional bits of the input format; 1.0 = 2^FRAC.
- `CLK_DIV`, 4: CLK cycles per SCLK half-period; ≥1.
- `SAMPLE_DIV`, 2268: CLK cycles per sample period; ≥2.
- `CLK`, input, 1: single system clock; all logic on the rising edge.
- `Reset`, input, 1: synchronous, active-low reset.
- `Sample`, input, W: signed filtered sample (filter `y`).
- `Sample_En`, output, 1: one-cycle strobe to the filter `Enable`.
- `SYNC`, output, 1: DAC frame select, active-low.
- `SCLK`, output, 1: DAC serial clock; idles high.
- `DIN`, output, 1: DAC serial data.
- `Busy`, output, 1: high while a frame is in progress (`SYNC` low).
- `Overrun`, output, 1: sticky flag, set when a captured sample replaces a pending one that was never sent.

## Operation
- Sample counter runs 0..SAMPLE_DIV-1 and wraps; `Sample_En`=1 exactly when the count is SAMPLE_DIV-1.
- Capture occurs in the cycle after `Sample_En`, once filter registers have updated. The converted code goes into the pending register, and `pending_valid` is set.
- Conversion uses an arithmetic right shift of `Sample` by FRAC-11, clamped to [-2048, 2047], plus 2048. The result is a 12-bit code.
- Frame layout is {4'b0000, code[11:0]}, 16 bits, MSB first.
- FSM states:
  - IDLE: `SYNC`=1, `SCLK`=1. When `pending_valid`, go to LOAD.
  - LOAD: `SYNC`=0. The shift register loads the frame, `pending_valid` clears, and `DIN` = bit 15. Hold CLK_DIV cycles, then go to SHIFT.
  - SHIFT: `SCLK` toggles every CLK_DIV cycles, starting with a fall. On each rise the shift register shifts left and `DIN` takes the next bit. After the 16th fall, go to STOP.
  - STOP: hold `SCLK` low CLK_DIV cycles. Then raise `SCLK` and `SYNC` together and return to IDLE.
- The DAC samples `DIN` on `SCLK` falling edges.
- If a capture arrives while `pending_valid`=1, the new code replaces the old one and `Overrun` is set. A capture during SHIFT does not disturb the frame in flight.
- If a capture and the LOAD transfer occur in the same cycle, LOAD takes the old pending code, the new code becomes pending, and `Overrun` is not set.

## Timing
- Reset values: `Sample_En`=0, `SYNC`=1, `SCLK`=1, `DIN`=0, `Busy`=0, `Overrun`=0. Counters, pending register and `pending_valid` are cleared, and the FSM is in IDLE.
- Reset asserted mid-frame aborts the frame. Outputs take their reset values on the next edge; no partial-frame completion.
- First `Sample_En` occurs SAMPLE_DIV cycles after reset release.
- Latency from `Sample_En` to `SYNC` falling is 2 cycles: capture, then LOAD entry.
- `SYNC` stays low for 34·CLK_DIV cycles: LOAD CLK_DIV, SHIFT 32·CLK_DIV, STOP CLK_DIV.
- `Overrun` never occurs in steady state when SAMPLE_DIV ≥ 34·CLK_DIV + 3.
- `Busy` == !`SYNC` at all times.

## Structure
- Shared package `dac_tx_pkg`:
  - FSM state enum (IDLE, LOAD, SHIFT, STOP).
  - `DAC_BITS`=12, `FRAME_BITS`=16, `PAD_BITS`=4.
  - Midscale constant 2048.
- One combinational sub-module, `sample_to_dac_code`, holds the shift, saturation and offset. It is parameterized by W and FRAC.
- Top module contains the sample counter, capture/pending logic, FSM, SCLK divider and shift register.

## Test plan
- Midscale: `Sample`=0 → frame 0x0800 on `DIN` across 16 falling edges, with `SYNC` low for exactly 34·CLK_DIV cycles. Use CLK_DIV=2, SAMPLE_DIV=100.
- Positive value and saturation: `Sample`=8192 (0.5) → code 0xC00. `Sample`=16384 and `Sample`=2^24-1 → code 0xFFF.
- Negative value and saturation: `Sample`=-16384 → code 0x000. `Sample`=-8192 → code 0x400. `Sample`=-2^24 → code 0x000.
- Strobe cadence: `Sample_En` pulses one cycle wide every 100 cycles, first at cycle 100 after reset release. `SYNC` falls 2 cycles after each pulse.
- Overrun: SAMPLE_DIV=40, CLK_DIV=2 → second capture arrives while a code is pending → `Overrun` goes high and stays high. The frame in flight is unaffected, and the latest code is sent next.
- Reset mid-frame: assert `Reset`=0 at the 7th `SCLK` fall → next edge gives `SYNC`=1, `SCLK`=1, `DIN`=0, `Busy`=0, `Overrun`=0. After release, the first frame starts 2 cycles after the first `Sample_En`.
